// File: rtl/f_pc_unit.sv
// Fetch-stage program counter: next-PC select, stall hold and fetch counter.
// Optional address-error flag F_ExcAdEL is built when F_PC_ADEL_CHECK_EN is defined.
module f_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_HIGH  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_index26,
  input  logic [31:0] D_jr_target,
  input  logic        D_br_taken,
  output logic [31:0] F_PC,
  output logic        F_valid,
`ifdef F_PC_ADEL_CHECK_EN
  output logic        F_ExcAdEL,
`endif
  output logic [31:0] F_fetch_cnt
);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q;
  logic [31:0] seq_pc;
  logic [31:0] br_target;

  assign seq_pc    = pc_q + 32'd4;
  assign br_target = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d  = seq_pc;
    cnt_d = cnt_q + 32'd1;
    unique case (npc_op_e'(NPCOp))
      NPC_SEQ:    pc_d = seq_pc;
      NPC_BRANCH: pc_d = D_br_taken ? br_target : seq_pc;
      NPC_JUMP:   pc_d = {D_PC[31:28], D_index26, 2'b00};
      NPC_JR:     pc_d = D_jr_target;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      // A stalled cycle freezes D as well, so the redirect is simply replayed later.
      if (!stall) begin
        pc_q  <= pc_d;
        cnt_q <= cnt_d;
      end
    end
  end

`ifdef F_PC_ADEL_CHECK_EN
  logic adel_q, adel_d;

  assign adel_d = (pc_d[1:0] != 2'b00) || (pc_d < PC_RESET) || (pc_d > PC_HIGH);

  // Flag tracks the value being loaded; the PC itself is never altered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adel_q <= 1'b0;
    end else if (!stall) begin
      adel_q <= adel_d;
    end
  end

  assign F_ExcAdEL = adel_q;
`endif

  assign F_PC        = pc_q;
  assign F_valid     = valid_q;
  assign F_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_f_pc_unit.sv
// Directed self-checking bench for f_pc_unit; outputs sampled 1ns after each rising edge.
// Address-error checks are included when F_PC_ADEL_CHECK_EN is defined.
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  NPCOp;
  logic [31:0] D_PC;
  logic [15:0] D_imm16;
  logic [25:0] D_index26;
  logic [31:0] D_jr_target;
  logic        D_br_taken;
  logic [31:0] F_PC;
  logic        F_valid;
  logic [31:0] F_fetch_cnt;
`ifdef F_PC_ADEL_CHECK_EN
  logic        F_ExcAdEL;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  f_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .NPCOp       (NPCOp),
    .D_PC        (D_PC),
    .D_imm16     (D_imm16),
    .D_index26   (D_index26),
    .D_jr_target (D_jr_target),
    .D_br_taken  (D_br_taken),
    .F_PC        (F_PC),
    .F_valid     (F_valid),
`ifdef F_PC_ADEL_CHECK_EN
    .F_ExcAdEL   (F_ExcAdEL),
`endif
    .F_fetch_cnt (F_fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc,
                             input logic [31:0] cnt, input logic vld);
    check({tag, ".pc"},    F_PC, pc);
    check({tag, ".cnt"},   F_fetch_cnt, cnt);
    check({tag, ".valid"}, {31'd0, F_valid}, {31'd0, vld});
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    NPCOp       = 2'b00;
    D_PC        = 32'h0;
    D_imm16     = 16'h0;
    D_index26   = 26'h0;
    D_jr_target = 32'h0;
    D_br_taken  = 1'b0;
    #1;
    check_state("por", 32'h3000, 32'd0, 1'b0);
    step(2);
    check_state("reset_held", 32'h3000, 32'd0, 1'b0);

    // Run sequentially up to 0x3010, then hit reset between edges.
    reset = 1'b0;
    step(4);
    check_state("seq4", 32'h3010, 32'd4, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_state("async_reset", 32'h3000, 32'd0, 1'b0);
`ifdef F_PC_ADEL_CHECK_EN
    check("async_reset.adel", {31'd0, F_ExcAdEL}, 32'd0);
`endif
    #1 reset = 1'b0;
    step(3);
    check_state("seq3", 32'h300C, 32'd3, 1'b1);

    // Taken branch backwards: 0x3008 + 4 - 8.
    NPCOp = 2'b01; D_PC = 32'h3008; D_imm16 = 16'hFFFE; D_br_taken = 1'b1;
    step(1);
    check_state("br_taken", 32'h3004, 32'd4, 1'b1);
    NPCOp = 2'b00;
    step(2);
    check("seq_to_300c", F_PC, 32'h300C);
    NPCOp = 2'b01; D_br_taken = 1'b0;
    step(1);
    check_state("br_not_taken", 32'h3010, 32'd7, 1'b1);

    // Jump and register jump.
    NPCOp = 2'b10; D_PC = 32'h3014; D_index26 = 26'h0000C03;
    step(1);
    check_state("jump", 32'h0000300C, 32'd8, 1'b1);
    NPCOp = 2'b10; D_PC = 32'hA000_0000; D_index26 = 26'h3FF_FFFF;
    step(1);
    check("jump_hi_bits", F_PC, 32'hAFFF_FFFC);
    NPCOp = 2'b11; D_jr_target = 32'h3040;
    step(1);
    check_state("jr", 32'h3040, 32'd10, 1'b1);

    // Stall holds across a pending taken branch, then the branch lands.
    stall = 1'b1; NPCOp = 2'b01; D_PC = 32'h3040; D_imm16 = 16'h0004; D_br_taken = 1'b1;
    step(2);
    check_state("stall_hold", 32'h3040, 32'd10, 1'b1);
    stall = 1'b0;
    step(1);
    check_state("stall_release", 32'h3054, 32'd11, 1'b1);

    // Most negative branch offset wraps through address zero.
    D_PC = 32'h0002_0000; D_imm16 = 16'h8000;
    step(1);
    check("br_min_offset", F_PC, 32'h0000_0004);
    D_PC = 32'h0; D_imm16 = 16'hFFFE;
    step(1);
    check("br_wrap_neg", F_PC, 32'hFFFF_FFFC);

    // Sequential increment wraps modulo 2^32.
    NPCOp = 2'b11; D_jr_target = 32'hFFFF_FFFC;
    step(1);
    NPCOp = 2'b00;
    step(1);
    check_state("pc_wrap", 32'h0000_0000, 32'd15, 1'b1);

`ifdef F_PC_ADEL_CHECK_EN
    NPCOp = 2'b11;
    D_jr_target = 32'h3042; step(1);
    check("adel_misaligned.pc", F_PC, 32'h3042);
    check("adel_misaligned", {31'd0, F_ExcAdEL}, 32'd1);
    D_jr_target = 32'h6FFC; step(1);
    check("adel_high_ok", {31'd0, F_ExcAdEL}, 32'd0);
    D_jr_target = 32'h7000; step(1);
    check("adel_above_high", {31'd0, F_ExcAdEL}, 32'd1);
    D_jr_target = 32'h3000; step(1);
    check("adel_low_ok", {31'd0, F_ExcAdEL}, 32'd0);
    D_jr_target = 32'h2FFC; step(1);
    check("adel_below_low", {31'd0, F_ExcAdEL}, 32'd1);
    stall = 1'b1; D_jr_target = 32'h3100; step(1);
    check("adel_stall_hold", {31'd0, F_ExcAdEL}, 32'd1);
    stall = 1'b0; step(1);
    check("adel_reload", {31'd0, F_ExcAdEL}, 32'd0);
    D_jr_target = 32'h7000; step(1);
`endif

    // Reset asserted mid-stall.
    stall = 1'b1; NPCOp = 2'b11; D_jr_target = 32'h5000;
    #2 reset = 1'b1;
    #1;
    check_state("reset_in_stall", 32'h3000, 32'd0, 1'b0);
`ifdef F_PC_ADEL_CHECK_EN
    check("reset_in_stall.adel", {31'd0, F_ExcAdEL}, 32'd0);
`endif
    #1 reset = 1'b0; stall = 1'b0; NPCOp = 2'b00;
    step(1);
    check_state("post_reset_seq", 32'h3004, 32'd1, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
